// File: rtl/ibuf_wr_pkg.sv
// ibuf_wr_pkg: shared FSM type, default widths and ratio helpers for the IBUF bank writer
package ibuf_wr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} wr_state_e;
  localparam int DEF_DDR_BANDWIDTH = 512;
  localparam int DEF_NUM_BANKS = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LEN_WIDTH = 16;
  function automatic int ratio_of(input int bw, input int banks, input int dw);
    return bw / (banks * dw);
  endfunction
  function automatic int word_idx_w(input int ratio);
    return ratio > 1 ? $clog2(ratio) : 1;
  endfunction
endpackage

// File: rtl/ibuf_beat_holder.sv
// ibuf_beat_holder: holds one accepted DDR beat and selects word word_idx of every bank
module ibuf_beat_holder
  import ibuf_wr_pkg::*;
#(
  parameter int DDR_BANDWIDTH = DEF_DDR_BANDWIDTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_IDX_W = word_idx_w(ratio_of(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH))
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            load_i,
  input  logic                            consume_i,
  input  logic [DDR_BANDWIDTH-1:0]        data_i,
  input  logic [WORD_IDX_W-1:0]           word_idx_i,
  output logic                            valid_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] slice_o
);
  localparam int RATIO = ratio_of(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH);
  logic [DDR_BANDWIDTH-1:0] data_q;
  logic                     valid_q;
  // Capture an accepted beat; a new load wins over releasing the previous one
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  assign valid_o = valid_q;
  for (genvar j = 0; j < NUM_BANKS; j++) begin : g_bank
    assign slice_o[j*DATA_WIDTH +: DATA_WIDTH] = data_q[(j*RATIO + int'(word_idx_i))*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: rtl/ibuf_bank_writer.sv
// ibuf_bank_writer: serialises bank-major DDR beats into parallel IBUF bank writes.
// Optional IBUF_WR_PERF_CNT_EN adds perf_beats / perf_stall_cycles counters.
module ibuf_bank_writer
  import ibuf_wr_pkg::*;
#(
  parameter int DDR_BANDWIDTH = DEF_DDR_BANDWIDTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [LEN_WIDTH-1:0]            num_beats,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DDR_BANDWIDTH-1:0]        in_data,
  output logic [NUM_BANKS-1:0]            bank_wr_en,
  output logic [ADDR_WIDTH-1:0]           bank_wr_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wr_data
`ifdef IBUF_WR_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_beats,
  output logic [31:0]                     perf_stall_cycles
`endif
);
  localparam int RATIO = ratio_of(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH);
  localparam int WIW = word_idx_w(RATIO);
  wr_state_e                     state_q, state_d;
  logic [LEN_WIDTH-1:0]          num_q, beats_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [WIW-1:0]                widx_q;
  logic                          hold_valid, last_word, accept, consume, tile_start;
  logic [NUM_BANKS*DATA_WIDTH-1:0] slice;
  assign tile_start = state_q == IDLE && start;
  assign last_word  = widx_q == WIW'(RATIO - 1);
  assign consume    = hold_valid && last_word;
  assign in_ready   = state_q == RUN && beats_q < num_q && (!hold_valid || last_word);
  assign accept     = in_valid && in_ready;
  ibuf_beat_holder #(
    .DDR_BANDWIDTH(DDR_BANDWIDTH),
    .NUM_BANKS(NUM_BANKS),
    .DATA_WIDTH(DATA_WIDTH),
    .WORD_IDX_W(WIW)
  ) u_holder (
    .clk(clk),
    .reset_n(reset_n),
    .load_i(accept),
    .consume_i(consume),
    .data_i(in_data),
    .word_idx_i(widx_q),
    .valid_o(hold_valid),
    .slice_o(slice)
  );
  // Tile sequencing: a zero-beat tile goes straight to DONE; RUN ends after the final word
  always_comb
    state_d = state_q == IDLE ? (start ? (num_beats == '0 ? DONE : RUN) : IDLE) :
              state_q == RUN  ? (consume && beats_q == num_q ? DONE : RUN) : IDLE;
  // State, tile length, beat count, running write address and word index
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      beats_q <= '0;
      addr_q  <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (tile_start) begin
        num_q   <= num_beats;
        beats_q <= '0;
        addr_q  <= base_addr;
        widx_q  <= '0;
      end else begin
        if (accept) beats_q <= beats_q + LEN_WIDTH'(1);
        if (hold_valid) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          widx_q <= last_word ? '0 : widx_q + WIW'(1);
        end
      end
    end
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign bank_wr_en   = {NUM_BANKS{hold_valid}};
  assign bank_wr_addr = hold_valid ? addr_q : '0;
  assign bank_wr_data = hold_valid ? slice : '0;
`ifdef IBUF_WR_PERF_CNT_EN
  logic [31:0] perf_beats_q, perf_stall_q;
  // Per-tile accepted-beat and upstream-starvation counters, saturating at all-ones
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
    end else if (tile_start) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept && ~&perf_beats_q) perf_beats_q <= perf_beats_q + 32'd1;
      if (state_q == RUN && !hold_valid && !in_valid && ~&perf_stall_q) perf_stall_q <= perf_stall_q + 32'd1;
    end
  assign perf_beats        = perf_beats_q;
  assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_ibuf_bank_writer.sv
// tb_ibuf_bank_writer: randomized directed checks of ibuf_bank_writer against a write-list model
module tb_ibuf_bank_writer;
  localparam int BW = 512;
  localparam int NB = 8;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int R = BW / (NB * DW);
  typedef struct packed {
    logic [AW-1:0]    a;
    logic [NB*DW-1:0] d;
  } exp_t;
  logic clk, reset_n, start, busy, done, in_valid, in_ready;
  logic [AW-1:0] base_addr, bank_wr_addr;
  logic [15:0] num_beats;
  logic [BW-1:0] in_data;
  logic [NB-1:0] bank_wr_en;
  logic [NB*DW-1:0] bank_wr_data;
`ifdef IBUF_WR_PERF_CNT_EN
  logic [31:0] perf_beats, perf_stall_cycles;
`endif
  int evals = 0, fails = 0, cyc = 0;
  logic [BW-1:0] saved[$];
  ibuf_bank_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data)
`ifdef IBUF_WR_PERF_CNT_EN
    , .perf_beats(perf_beats), .perf_stall_cycles(perf_stall_cycles)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    evals++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    for (int w = 0; w < BW / 32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction
  task automatic run_tile(input logic [AW-1:0] base, input int n, input int gap, input bit byte_pat, input bit reuse, input bit mid_start);
    logic [BW-1:0] beats[$];
    exp_t q[$];
    exp_t e;
    int bi = 0, writes = 0, s, first_wr = -1, last_wr = -1, done_cyc = -1, acc0 = -1;
    bit saw_ready = 0;
    for (int b = 0; b < n; b++) begin
      logic [BW-1:0] v;
      if (byte_pat) for (int k = 0; k < BW / 8; k++) v[k*8 +: 8] = 8'(k);
      else v = reuse ? saved[b] : rand_beat();
      beats.push_back(v);
      for (int i = 0; i < R; i++) begin
        e.a = AW'(int'(base) + b * R + i);
        for (int j = 0; j < NB; j++) e.d[j*DW +: DW] = v[(j*R + i)*DW +: DW];
        q.push_back(e);
      end
    end
    saved = beats;
    in_valid = 0;
    start = 1;
    base_addr = base;
    num_beats = 16'(n);
    s = cyc;
    check("idle_ready", in_ready, 0);
    tick();
    start = 0;
    for (int k = 0; k < n * (R + 20) + 20 && done_cyc < 0; k++) begin
      in_valid = bi < n ? $urandom_range(99) >= gap : 1'b1;
      in_data = in_valid && bi < n ? beats[bi] : rand_beat();
      start = mid_start && k == 3;
      base_addr = start ? ~base : base;
      num_beats = start ? 16'd7 : 16'(n);
      if (in_ready) begin
        saw_ready = 1;
        check("ready_beats_remain", bi < n, 1);
      end
      if (bank_wr_en != '0) begin
        writes++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        check("wr_en_all", bank_wr_en, {NB{1'b1}});
        if (q.size() == 0) check("extra_write", 1, 0);
        else begin
          e = q.pop_front();
          check("wr_addr", bank_wr_addr, e.a);
          check("wr_data", bank_wr_data, e.d);
        end
      end
      if (done) done_cyc = cyc;
      if (in_valid && in_ready) begin
        if (bi == 0) acc0 = cyc;
        bi++;
      end
      tick();
    end
    in_valid = 0;
    start = 0;
    check("done_seen", done_cyc >= 0, 1);
    check("write_count", writes, n * R);
    check("done_latency", done_cyc - (n > 0 ? last_wr : s), 1);
    if (n > 0) check("first_write_latency", first_wr - acc0, 1);
    if (n > 0 && gap == 0) check("no_bubble", last_wr - first_wr + 1, n * R);
    if (n == 0) check("ready_never", saw_ready, 0);
    check("done_single", done, 0);
    check("idle_busy", busy, 0);
  endtask
  initial begin
    bit found;
    reset_n = 0; start = 0; base_addr = '0; num_beats = '0; in_valid = 0; in_data = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    check("rst_en", bank_wr_en, 0);
    check("rst_addr", bank_wr_addr, 0);
    check("rst_data", bank_wr_data, 0);
    tick();
    reset_n = 1;
    tick();
    run_tile(10'h010, 1, 0, 1, 0, 0);
    run_tile(10'h010, 4, 0, 0, 0, 0);
`ifdef IBUF_WR_PERF_CNT_EN
    check("perf_beats", perf_beats, 4);
`endif
    run_tile(10'h010, 4, 50, 0, 1, 0);
    run_tile(10'h3FC, 1, 0, 0, 0, 0);
    run_tile(10'h000, 0, 0, 0, 0, 0);
    run_tile(10'h123, 3, 20, 0, 0, 1);
    for (int t = 0; t < 4; t++)
      run_tile(AW'($urandom_range(1023)), $urandom_range(0, 5), $urandom_range(0, 70), 0, 0, 0);
    start = 1; base_addr = 10'h100; num_beats = 16'd4; in_valid = 0;
    tick();
    start = 0; in_valid = 1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      in_data = rand_beat();
      if (bank_wr_en != '0 && bank_wr_addr == AW'(10'h100 + R + 2)) found = 1;
      else tick();
    end
    check("rst_point_reached", found, 1);
    #1 reset_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_en", bank_wr_en, 0);
    check("midrst_addr", bank_wr_addr, 0);
    check("midrst_data", bank_wr_data, 0);
    tick();
    reset_n = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_en", bank_wr_en, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", in_ready, 0);
    end
    in_valid = 0;
    run_tile(10'h200, 2, 30, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule
